// File: rtl/fifo_wr_ptr_ctrl.sv
// fifo_wr_ptr_ctrl
//   Write-domain pointer control for an asynchronous FIFO. It keeps a binary
//   write pointer that drives the memory address, and exports a registered
//   Gray copy of that pointer to the read domain. It also brings the read
//   domain's Gray pointer into W_CLK and derives full, almost-full, fill level
//   and a sticky overflow flag from it.
//   Parameter limits: ADDR_WIDTH >= 2, SYNC_STAGES >= 2,
//   1 <= AFULL_THRESH <= 2**ADDR_WIDTH.
module fifo_wr_ptr_ctrl #(
  parameter int ADDR_WIDTH   = 3,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 6
) (
  input  logic                  W_CLK,
  input  logic                  W_RST,
  input  logic                  winc,
  input  logic                  wclr_ovf,
  input  logic [ADDR_WIDTH:0]   r_gptr,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH:0]   w_gptr,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  woverflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_L = PW'(AFULL_THRESH);

  // Gray code to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Binary to Gray: adjacent values differ in exactly one bit.
  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // State registers and their next-state values.
  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] w_gptr_q, w_gptr_d;
  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic          wfull_q, wfull_d;
  logic          walmost_full_q, walmost_full_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          woverflow_q, woverflow_d;

  // Combinational helpers.
  logic          wpush_s;
  logic [PW-1:0] wq_rptr_s;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] full_gray_s;

  assign wq_rptr_s = sync_q[SYNC_STAGES-1];
  assign rbin_s    = gray2bin(wq_rptr_s);

  // Full pattern: the write pointer is exactly one lap ahead of the read
  // pointer, which in Gray form means the two MSBs are inverted.
  assign full_gray_s = {~wq_rptr_s[PW-1:PW-2], wq_rptr_s[PW-3:0]};

  // Next-state logic: pointer advance, flags and level all derive from wbin_d,
  // so full asserts on the very edge that performs the filling write.
  always_comb begin
    wpush_s        = winc & ~wfull_q;
    wbin_d         = wbin_q + {{ADDR_WIDTH{1'b0}}, wpush_s};
    w_gptr_d       = bin2gray(wbin_d);
    wfull_d        = (w_gptr_d == full_gray_s);
    wlevel_d       = wbin_d - rbin_s;
    walmost_full_d = (wlevel_d >= AFULL_L);
    if (winc && wfull_q) begin
      woverflow_d = 1'b1;
    end else if (wclr_ovf) begin
      woverflow_d = 1'b0;
    end else begin
      woverflow_d = woverflow_q;
    end
  end

  // Pointer, flag and level registers; async active-low reset.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wbin_q         <= {PW{1'b0}};
      w_gptr_q       <= {PW{1'b0}};
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wlevel_q       <= {PW{1'b0}};
      woverflow_q    <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      w_gptr_q       <= w_gptr_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      wlevel_q       <= wlevel_d;
      woverflow_q    <= woverflow_d;
    end
  end

  // Read-pointer synchroniser chain; nothing else samples r_gptr.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= {PW{1'b0}};
      end
    end else begin
      sync_q[0] <= r_gptr;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign w_addr       = wbin_q[ADDR_WIDTH-1:0];
  assign w_gptr       = w_gptr_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = woverflow_q;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Directed and randomised checks for fifo_wr_ptr_ctrl with ADDR_WIDTH=3,
// SYNC_STAGES=2, AFULL_THRESH=6.
`timescale 1ns/100ps
module tb_fifo_wr_ptr_ctrl;

  logic       W_CLK = 1'b0;
  logic       W_RST = 1'b0;
  logic       winc = 1'b0;
  logic       wclr_ovf = 1'b0;
  logic [3:0] r_gptr;
  logic [2:0] w_addr;
  logic [3:0] w_gptr;
  logic       wfull;
  logic       walmost_full;
  logic [3:0] wlevel;
  logic       woverflow;

  logic       rclk = 1'b0;
  logic       rd_mode = 1'b0;
  logic [3:0] r_gptr_dir = 4'd0;
  logic [3:0] r_gptr_rnd;
  logic [3:0] rcount;
  logic [3:0] wcount_tb = 4'd0;

  int tests = 0;
  int fails = 0;

  fifo_wr_ptr_ctrl #(
    .ADDR_WIDTH  (3),
    .SYNC_STAGES (2),
    .AFULL_THRESH(6)
  ) dut (
    .W_CLK       (W_CLK),
    .W_RST       (W_RST),
    .winc        (winc),
    .wclr_ovf    (wclr_ovf),
    .r_gptr      (r_gptr),
    .w_addr      (w_addr),
    .w_gptr      (w_gptr),
    .wfull       (wfull),
    .walmost_full(walmost_full),
    .wlevel      (wlevel),
    .woverflow   (woverflow)
  );

  always #5 W_CLK = ~W_CLK;
  always #3.7 rclk = ~rclk;

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  // Read side model: an asynchronous reader that never passes the writer.
  always @(posedge rclk) begin
    if (!rd_mode) rcount <= 4'd0;
    else if (rcount != wcount_tb && $urandom_range(0, 1) == 1) rcount <= rcount + 4'd1;
  end

  assign r_gptr_rnd = gray4(rcount);
  assign r_gptr     = rd_mode ? r_gptr_rnd : r_gptr_dir;

  task automatic tick;
    @(posedge W_CLK);
    #1;
  endtask

  task automatic test_reset;
    logic [13:0] all_s;
    W_RST = 1'b0; winc = 1'b0; r_gptr_dir = 4'd0;
    #12;
    all_s = {w_addr, w_gptr, wfull, walmost_full, wlevel, woverflow};
    tests++;
    if (all_s !== 14'd0) begin
      fails++; $display("FAIL reset_initial: got %h want 0", all_s);
    end
    @(negedge W_CLK);
    W_RST = 1'b1; winc = 1'b1;
    tick; tick; tick;
    tests++;
    if (w_addr !== 3'd3) begin
      fails++; $display("FAIL reset_prefill_addr: got %0d want 3", w_addr);
    end
    #2;
    W_RST = 1'b0;
    #1;
    all_s = {w_addr, w_gptr, wfull, walmost_full, wlevel, woverflow};
    tests++;
    if (all_s !== 14'd0) begin
      fails++; $display("FAIL reset_async: got %h want 0", all_s);
    end
    tick;
    all_s = {w_addr, w_gptr, wfull, walmost_full, wlevel, woverflow};
    tests++;
    if (all_s !== 14'd0) begin
      fails++; $display("FAIL reset_next_cycle: got %h want 0", all_s);
    end
    @(negedge W_CLK);
    winc = 1'b0;
    W_RST = 1'b1;
    tick;
  endtask

  task automatic test_fill;
    logic [3:0] gexp [8];
    gexp = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC};
    winc = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (w_addr !== i[2:0]) begin
        fails++; $display("FAIL fill_addr[%0d]: got %0d want %0d", i, w_addr, i);
      end
      tick;
      tests++;
      if (w_gptr !== gexp[i]) begin
        fails++; $display("FAIL fill_gptr[%0d]: got %h want %h", i, w_gptr, gexp[i]);
      end
      tests++;
      if (walmost_full !== (i >= 5)) begin
        fails++; $display("FAIL fill_afull[%0d]: got %b want %b", i, walmost_full, (i >= 5));
      end
      tests++;
      if (wfull !== (i == 7)) begin
        fails++; $display("FAIL fill_full[%0d]: got %b want %b", i, wfull, (i == 7));
      end
      tests++;
      if (wlevel !== 4'(i + 1)) begin
        fails++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, wlevel, i + 1);
      end
    end
  endtask

  task automatic test_overflow;
    winc = 1'b1; wclr_ovf = 1'b0;
    tick;
    tests++;
    if ({w_addr, w_gptr, wfull, woverflow} !== {3'd0, 4'hC, 1'b1, 1'b1}) begin
      fails++; $display("FAIL ovf_hold: got addr=%0d gptr=%h full=%b ovf=%b want 0 C 1 1",
                        w_addr, w_gptr, wfull, woverflow);
    end
    winc = 1'b1; wclr_ovf = 1'b1;
    tick;
    tests++;
    if (woverflow !== 1'b1) begin
      fails++; $display("FAIL ovf_set_wins: got %b want 1", woverflow);
    end
    winc = 1'b0; wclr_ovf = 1'b1;
    tick;
    tests++;
    if (woverflow !== 1'b0) begin
      fails++; $display("FAIL ovf_clear: got %b want 0", woverflow);
    end
    wclr_ovf = 1'b0;
  endtask

  task automatic test_read_release;
    r_gptr_dir = 4'b0110;
    tick; tick;
    tests++;
    if (wfull !== 1'b1 || wlevel !== 4'd8) begin
      fails++; $display("FAIL release_early: got full=%b level=%0d want 1 8", wfull, wlevel);
    end
    tick;
    tests++;
    if ({wfull, wlevel, walmost_full} !== {1'b0, 4'd4, 1'b0}) begin
      fails++; $display("FAIL release_latency: got full=%b level=%0d afull=%b want 0 4 0",
                        wfull, wlevel, walmost_full);
    end
  endtask

  task automatic test_wrap;
    for (int k = 5; k <= 8; k++) begin
      r_gptr_dir = gray4(4'(k));
      tick;
    end
    tick; tick; tick;
    tests++;
    if (wlevel !== 4'd0) begin
      fails++; $display("FAIL wrap_drain_level: got %0d want 0", wlevel);
    end
    winc = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      r_gptr_dir = gray4(4'(7 + j));
      tick;
      tests++;
      if (wfull !== 1'b0) begin
        fails++; $display("FAIL wrap_write_full[%0d]: got %b want 0", j, wfull);
      end
    end
    winc = 1'b0;
    r_gptr_dir = 4'b0000;
    tick; tick; tick;
    tests++;
    if ({w_gptr, wlevel, wfull} !== {4'h0, 4'd0, 1'b0}) begin
      fails++; $display("FAIL wrap_empty: got gptr=%h level=%0d full=%b want 0 0 0",
                        w_gptr, wlevel, wfull);
    end
    winc = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick;
      if (j == 7) begin
        tests++;
        if (wfull !== 1'b0) begin
          fails++; $display("FAIL wrap_refill_7: got full=%b want 0", wfull);
        end
      end
    end
    winc = 1'b0;
    tests++;
    if ({wfull, wlevel} !== {1'b1, 4'd8}) begin
      fails++; $display("FAIL wrap_refill_full: got full=%b level=%0d want 1 8", wfull, wlevel);
    end
  endtask

  task automatic test_random;
    logic [3:0] prev_g;
    logic       prev_full;
    logic       push;
    logic [3:0] tl;
    wcount_tb = 4'd8;
    winc = 1'b0;
    rd_mode = 1'b1;
    for (int n = 0; n < 400; n++) begin
      winc = ($urandom_range(0, 3) != 0);
      prev_g = w_gptr;
      prev_full = wfull;
      push = winc && !prev_full;
      tick;
      if (push) wcount_tb = wcount_tb + 4'd1;
      tl = wcount_tb - rcount;
      tests++;
      if (w_gptr !== gray4(wcount_tb)) begin
        fails++; $display("FAIL rnd_gptr[%0d]: got %h want %h", n, w_gptr, gray4(wcount_tb));
      end
      tests++;
      if ($countones(w_gptr ^ prev_g) != (push ? 1 : 0)) begin
        fails++; $display("FAIL rnd_onebit[%0d]: got %h after %h push=%b", n, w_gptr, prev_g, push);
      end
      tests++;
      if (wlevel > 4'd8 || wlevel < tl) begin
        fails++; $display("FAIL rnd_level[%0d]: got %0d want %0d..8", n, wlevel, tl);
      end
      tests++;
      if (tl == 4'd8 && wfull !== 1'b1) begin
        fails++; $display("FAIL rnd_full[%0d]: got %b want 1", n, wfull);
      end
    end
    winc = 1'b0;
  endtask

  initial begin
    test_reset;
    test_fill;
    test_overflow;
    test_read_release;
    test_wrap;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
